// File: rtl/ps_bc_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : ps_bc_bus_arbiter_if
// Purpose  : Bundles the request/grant handshake and the bus-connect select
//            outputs between the PS decoder and the PS bus arbiter.
// Signals  : ps_req[3:0]        level requests (imm, stack, DM, ureg)
//            ps_popstck         stack request is a pop
//            ps_dm_wrb          DM request is a write
//            ps_ureg_add[3:0]   source register address
//            ps_dm_wait[W-1:0]  DM wait states for the access
//            ps_gnt[3:0]        one-hot grant
//            ps_done            final-cycle pulse of a transaction
//            ps_bc_drr_slct     registered drr select
//            ps_bc_di_slct      registered di select
//            ps_stall           decode stall
// Modports : master = decoder side, slave = arbiter side
// Revision : 1.0 - initial release
// ============================================================================
interface ps_bc_bus_arbiter_if #(
    parameter int WAIT_W = 2
);
    logic [3:0]        ps_req;
    logic              ps_popstck;
    logic              ps_dm_wrb;
    logic [3:0]        ps_ureg_add;
    logic [WAIT_W-1:0] ps_dm_wait;
    logic [3:0]        ps_gnt;
    logic              ps_done;
    logic [1:0]        ps_bc_drr_slct;
    logic [1:0]        ps_bc_di_slct;
    logic              ps_stall;

    modport master (
        output ps_req, ps_popstck, ps_dm_wrb, ps_ureg_add, ps_dm_wait,
        input  ps_gnt, ps_done, ps_bc_drr_slct, ps_bc_di_slct, ps_stall
    );

    modport slave (
        input  ps_req, ps_popstck, ps_dm_wrb, ps_ureg_add, ps_dm_wait,
        output ps_gnt, ps_done, ps_bc_drr_slct, ps_bc_di_slct, ps_stall
    );
endinterface
`default_nettype wire

// File: rtl/ps_bc_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ps_bc_bus_arbiter
// Purpose  : Arbitrates the shared PS data-bus connect between the immediate
//            load, stack push/pop, DM access and ureg transfer requesters.
//            Holds one grant for the whole transaction (including DM wait
//            states) and drives the registered bus-connect select codes.
// Ports    : clk    - system clock, rising edge
//            rst_n  - asynchronous active-low reset
//            bus    - ps_bc_bus_arbiter_if.slave (requests, grant, done,
//                     drr/di selects, stall)
// Revision : 1.0 - initial release
// ============================================================================
module ps_bc_bus_arbiter #(
    parameter int WAIT_W = 2
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    ps_bc_bus_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    localparam logic [1:0]        c_sel_idle = 2'b11;
    localparam logic [WAIT_W-1:0] c_wait_one = {{(WAIT_W-1){1'b0}}, 1'b1};
    localparam logic [WAIT_W-1:0] c_wait_zero = '0;

    // Registered state
    state_t            r_state;
    logic [3:0]        r_gnt;
    logic [1:0]        r_drr;
    logic [1:0]        r_di;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [1:0]        r_rr_ptr;      // 1..3, first round-robin candidate

    // Next-state values
    state_t            w_state_nxt;
    logic [3:0]        w_gnt_nxt;
    logic [1:0]        w_drr_nxt;
    logic [1:0]        w_di_nxt;
    logic [WAIT_W-1:0] w_wait_nxt;
    logic [1:0]        w_rr_ptr_nxt;

    // Arbitration
    logic              w_done;
    logic              w_dm_pending;
    logic [3:0]        w_req_m;
    logic [3:0]        w_win;
    logic [1:0]        w_src_drr;
    logic [1:0]        w_win_drr;
    logic [1:0]        w_win_di;

    // A DM grant with a non-zero captured wait count does not finish in XFER.
    assign w_dm_pending = r_gnt[2] && (r_wait_cnt != c_wait_zero);

    always_comb begin
        w_done = 1'b0;
        case (r_state)
            S_XFER:  w_done = !w_dm_pending;
            S_WAIT:  w_done = (r_wait_cnt == c_wait_one);
            default: w_done = 1'b0;
        endcase
    end

    // In the done cycle the completing requester is still holding its
    // request; mask it so the next grant goes elsewhere without a bubble.
    assign w_req_m = bus.ps_req & ~(w_done ? r_gnt : 4'b0000);

    // Immediate is fixed highest; stack/DM/ureg rotate from r_rr_ptr.
    always_comb begin
        w_win = 4'b0000;
        if (w_req_m[0]) begin
            w_win = 4'b0001;
        end else begin
            case (r_rr_ptr)
                2'd2: begin
                    if      (w_req_m[2]) w_win = 4'b0100;
                    else if (w_req_m[3]) w_win = 4'b1000;
                    else if (w_req_m[1]) w_win = 4'b0010;
                end
                2'd3: begin
                    if      (w_req_m[3]) w_win = 4'b1000;
                    else if (w_req_m[1]) w_win = 4'b0010;
                    else if (w_req_m[2]) w_win = 4'b0100;
                end
                default: begin
                    if      (w_req_m[1]) w_win = 4'b0010;
                    else if (w_req_m[2]) w_win = 4'b0100;
                    else if (w_req_m[3]) w_win = 4'b1000;
                end
            endcase
        end
    end

    // Source register to drr code for push / DM write / ureg transfer.
    always_comb begin
        case (bus.ps_ureg_add)
            4'd0:       w_src_drr = 2'b10;
            4'd1, 4'd2: w_src_drr = 2'b00;
            4'd6, 4'd7: w_src_drr = 2'b01;
            default:    w_src_drr = 2'b11;
        endcase
    end

    // Select codes for the candidate winner, registered alongside the grant.
    always_comb begin
        w_win_di  = c_sel_idle;
        w_win_drr = c_sel_idle;
        case (w_win)
            4'b0001: begin
                w_win_di  = 2'b10;
                w_win_drr = 2'b11;
            end
            4'b0010: begin
                w_win_di  = 2'b01;
                w_win_drr = bus.ps_popstck ? 2'b01 : w_src_drr;
            end
            4'b0100: begin
                w_win_di  = bus.ps_dm_wrb ? 2'b01 : 2'b00;
                w_win_drr = bus.ps_dm_wrb ? w_src_drr : 2'b11;
            end
            4'b1000: begin
                w_win_di  = 2'b01;
                w_win_drr = w_src_drr;
            end
            default: begin
                w_win_di  = c_sel_idle;
                w_win_drr = c_sel_idle;
            end
        endcase
    end

    // Next-state / output logic
    always_comb begin
        w_state_nxt  = r_state;
        w_gnt_nxt    = r_gnt;
        w_drr_nxt    = r_drr;
        w_di_nxt     = r_di;
        w_wait_nxt   = r_wait_cnt;
        w_rr_ptr_nxt = r_rr_ptr;

        if (r_state == S_WAIT) begin
            w_wait_nxt = r_wait_cnt - c_wait_one;
        end
        if (r_state == S_XFER && w_dm_pending) begin
            w_state_nxt = S_WAIT;
        end

        // Only round-robin winners move the pointer, to the slot after them.
        if (w_done) begin
            if (r_gnt[1]) w_rr_ptr_nxt = 2'd2;
            if (r_gnt[2]) w_rr_ptr_nxt = 2'd3;
            if (r_gnt[3]) w_rr_ptr_nxt = 2'd1;
        end

        if (r_state == S_IDLE || w_done) begin
            if (w_win != 4'b0000) begin
                w_state_nxt = S_XFER;
                w_gnt_nxt   = w_win;
                w_drr_nxt   = w_win_drr;
                w_di_nxt    = w_win_di;
                w_wait_nxt  = bus.ps_dm_wait;
            end else begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = 4'b0000;
                w_drr_nxt   = c_sel_idle;
                w_di_nxt    = c_sel_idle;
                w_wait_nxt  = c_wait_zero;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_gnt      <= 4'b0000;
            r_drr      <= c_sel_idle;
            r_di       <= c_sel_idle;
            r_wait_cnt <= c_wait_zero;
            r_rr_ptr   <= 2'd1;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_drr      <= w_drr_nxt;
            r_di       <= w_di_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
        end
    end

    assign bus.ps_gnt         = r_gnt;
    assign bus.ps_done        = w_done;
    assign bus.ps_bc_drr_slct = r_drr;
    assign bus.ps_bc_di_slct  = r_di;

    // Held low while in reset even if requests are already asserted.
    assign bus.ps_stall = rst_n && ((|(bus.ps_req & ~r_gnt)) ||
                                    (r_state == S_WAIT) ||
                                    (r_state == S_XFER && w_dm_pending));

endmodule
`default_nettype wire

// File: tb/tb_ps_bc_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps_bc_bus_arbiter
// Purpose  : Self-checking bench for ps_bc_bus_arbiter. A transaction-level
//            model (owner, remaining cycles, round-robin pointer) predicts
//            every output each cycle; directed sequences add literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps_bc_bus_arbiter;

    localparam int WAIT_W = 2;

    logic clk;
    logic rst_n;

    ps_bc_bus_arbiter_if #(.WAIT_W(WAIT_W)) bus ();

    ps_bc_bus_arbiter #(.WAIT_W(WAIT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    int         m_owner = -1;   // granted requester index, -1 when idle
    int         m_rem   = 0;    // cycles left in the transaction, incl. current
    int         m_rr    = 1;    // first round-robin candidate (1..3)
    int         m_capw  = 0;    // DM wait captured at grant
    logic [1:0] m_di    = 2'b11;
    logic [1:0] m_drr   = 2'b11;

    function automatic logic [1:0] src_code(input int a);
        if (a == 0) return 2'b10;
        if (a == 6 || a == 7) return 2'b01;
        if (a == 1 || a == 2) return 2'b00;
        return 2'b11;
    endfunction

    function automatic int pick(input logic [3:0] r, input int rr);
        int idx;
        if (r[0]) return 0;
        for (int k = 0; k < 3; k++) begin
            idx = ((rr - 1 + k) % 3) + 1;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic m_start(input int w);
        if (w < 0) begin
            m_owner = -1; m_rem = 0; m_capw = 0; m_di = 2'b11; m_drr = 2'b11;
        end else begin
            m_owner = w;
            m_capw  = (w == 2) ? int'(bus.ps_dm_wait) : 0;
            m_rem   = m_capw + 1;
            case (w)
                0: begin m_di = 2'b10; m_drr = 2'b11; end
                1: begin m_di = 2'b01; m_drr = bus.ps_popstck ? 2'b01 : src_code(int'(bus.ps_ureg_add)); end
                2: begin
                    m_di  = bus.ps_dm_wrb ? 2'b01 : 2'b00;
                    m_drr = bus.ps_dm_wrb ? src_code(int'(bus.ps_ureg_add)) : 2'b11;
                end
                default: begin m_di = 2'b01; m_drr = src_code(int'(bus.ps_ureg_add)); end
            endcase
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_owner = -1; m_rem = 0; m_rr = 1; m_capw = 0;
                m_di = 2'b11; m_drr = 2'b11;
            end else if (m_owner < 0) begin
                m_start(pick(bus.ps_req, m_rr));
            end else if (m_rem == 1) begin
                int w;
                w = pick(bus.ps_req & ~(4'(1) << m_owner), m_rr);
                if (m_owner != 0) m_rr = (m_owner == 3) ? 1 : m_owner + 1;
                m_start(w);
            end else begin
                m_rem--;
            end
        end
    end

    // ---------------- per-cycle comparison against the model ----------------
    initial begin
        logic [3:0] e_gnt;
        logic       e_stall;
        forever begin
            @(negedge clk);
            e_gnt   = (m_owner < 0) ? 4'b0000 : (4'(1) << m_owner);
            e_stall = rst_n && (((bus.ps_req & ~e_gnt) != 4'b0000) ||
                                (m_owner == 2 && m_capw > 0));
            chk("model_gnt",   bus.ps_gnt, e_gnt);
            chk("model_done",  {3'b0, bus.ps_done}, {3'b0, (m_owner >= 0 && m_rem == 1)});
            chk("model_drr",   {2'b0, bus.ps_bc_drr_slct}, {2'b0, m_drr});
            chk("model_di",    {2'b0, bus.ps_bc_di_slct}, {2'b0, m_di});
            chk("model_stall", {3'b0, bus.ps_stall}, {3'b0, e_stall});
            chk("model_onehot", {3'b0, $onehot0(bus.ps_gnt)}, 4'b0001);
        end
    end

    // ---------------- stimulus ----------------
    task automatic lit(input string nm, input logic [3:0] gnt, input logic [1:0] di,
                       input logic [1:0] drr, input logic done);
        chk({nm, "_gnt"},  bus.ps_gnt, gnt);
        chk({nm, "_di"},   {2'b0, bus.ps_bc_di_slct}, {2'b0, di});
        chk({nm, "_drr"},  {2'b0, bus.ps_bc_drr_slct}, {2'b0, drr});
        chk({nm, "_done"}, {3'b0, bus.ps_done}, {3'b0, done});
    endtask

    logic [1:0] sweep_exp [16] = '{2'b10, 2'b00, 2'b00, 2'b11, 2'b11, 2'b11, 2'b01, 2'b01,
                                   2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11};
    logic [3:0] rr_exp [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0010};

    initial begin
        rst_n = 1'b0;
        bus.ps_req = 4'b0000; bus.ps_popstck = 1'b0; bus.ps_dm_wrb = 1'b0;
        bus.ps_ureg_add = 4'd0; bus.ps_dm_wait = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        lit("reset", 4'b0000, 2'b11, 2'b11, 1'b0);
        chk("reset_stall", {3'b0, bus.ps_stall}, 4'b0000);
        @(posedge clk); #2 rst_n = 1'b1;

        // Single immediate load
        @(posedge clk); #2 bus.ps_req = 4'b0001;
        @(posedge clk); #2 bus.ps_req = 4'b0000;
        @(negedge clk); lit("imm", 4'b0001, 2'b10, 2'b11, 1'b1);
        @(posedge clk); @(negedge clk); lit("imm_idle", 4'b0000, 2'b11, 2'b11, 1'b0);

        // Round robin, back-to-back, no waits
        #2 bus.ps_req = 4'b1110; bus.ps_ureg_add = 4'd3;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #2;
            if (i == 3) bus.ps_req = 4'b0000;
            @(negedge clk);
            chk("rr_gnt", bus.ps_gnt, rr_exp[i]);
            chk("rr_done", {3'b0, bus.ps_done}, 4'b0001);
        end

        // DM write with two wait states, then immediate and ureg during wait
        @(posedge clk); #2;
        bus.ps_req = 4'b0100; bus.ps_dm_wrb = 1'b1; bus.ps_ureg_add = 4'd6; bus.ps_dm_wait = 2'd2;
        @(posedge clk); #2 bus.ps_req = 4'b0000;
        @(negedge clk); lit("dm1", 4'b0100, 2'b01, 2'b01, 1'b0);
        chk("dm1_stall", {3'b0, bus.ps_stall}, 4'b0001);
        @(posedge clk); #2 bus.ps_req = 4'b1001; bus.ps_ureg_add = 4'd0;
        @(negedge clk); lit("dm2", 4'b0100, 2'b01, 2'b01, 1'b0);
        chk("dm2_stall", {3'b0, bus.ps_stall}, 4'b0001);
        @(posedge clk); #2;
        @(negedge clk); lit("dm3", 4'b0100, 2'b01, 2'b01, 1'b1);
        @(posedge clk); #2 bus.ps_req = 4'b1000;
        @(negedge clk); lit("after_dm_imm", 4'b0001, 2'b10, 2'b11, 1'b1);
        @(posedge clk); #2 bus.ps_req = 4'b0000;
        @(negedge clk); lit("after_dm_ureg", 4'b1000, 2'b01, 2'b10, 1'b1);

        // Ureg source decode sweep
        for (int a = 0; a < 16; a++) begin
            @(posedge clk); #2 bus.ps_req = 4'b1000; bus.ps_ureg_add = 4'(a);
            @(posedge clk); #2 bus.ps_req = 4'b0000;
            @(negedge clk);
            chk("sweep_drr", {2'b0, bus.ps_bc_drr_slct}, {2'b0, sweep_exp[a]});
            chk("sweep_di",  {2'b0, bus.ps_bc_di_slct}, 4'b0001);
        end

        // Stack pop moves the pointer to 2, then reset in a DM wait
        @(posedge clk); #2 bus.ps_req = 4'b0010; bus.ps_popstck = 1'b1;
        @(posedge clk); #2 bus.ps_req = 4'b0000;
        @(negedge clk); lit("pop", 4'b0010, 2'b01, 2'b01, 1'b1);
        @(posedge clk); #2 bus.ps_req = 4'b0110; bus.ps_dm_wrb = 1'b0; bus.ps_dm_wait = 2'd3;
        @(posedge clk); #2;
        @(negedge clk); lit("dmrd", 4'b0100, 2'b00, 2'b11, 1'b0);
        @(posedge clk); @(posedge clk); #2 rst_n = 1'b0;
        @(negedge clk); lit("mid_rst", 4'b0000, 2'b11, 2'b11, 1'b0);
        chk("mid_rst_stall", {3'b0, bus.ps_stall}, 4'b0000);
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #2 bus.ps_req = 4'b0000;
        @(negedge clk); lit("post_rst", 4'b0010, 2'b01, 2'b01, 1'b1);

        // Randomized traffic, with occasional asynchronous reset pulses
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #2;
            if (!rst_n) rst_n = 1'b1;
            bus.ps_req      = 4'($urandom & $urandom);
            bus.ps_popstck  = 1'($urandom);
            bus.ps_dm_wrb   = 1'($urandom);
            bus.ps_ureg_add = 4'($urandom);
            bus.ps_dm_wait  = WAIT_W'($urandom);
            if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
        end
        @(posedge clk); #2 rst_n = 1'b1; bus.ps_req = 4'b0000;
        repeat (6) @(posedge clk);
        @(negedge clk); #1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps_bc_bus_arbiter.md
Name: ps_bc_bus_arbiter

Overview:
- Arbitrates the shared PS data-bus connect between four requesters: immediate load, stack push/pop, DM access, universal-register transfer.
- Grants one transaction at a time and holds it for the required number of cycles, including DM wait states.
- Drives the registered bus-connect select codes (drr/di) for the granted transaction, plus a decode stall.
- Sits between the PS decoder and the bus-connect mux.

Parameters:
- WAIT_W, 2, width of the DM wait-state count input; max wait = 2^WAIT_W-1 cycles.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ps_req  in  4  level requests; bit0 immediate, bit1 stack, bit2 DM, bit3 ureg transfer; held until matching ps_done.
- ps_popstck  in  1  stack request is a pop (1) or push (0); sampled at grant.
- ps_dm_wrb  in  1  DM request is a write (1) or read (0); sampled at grant.
- ps_ureg_add  in  4  source register address for push/DM-write/ureg transfer; sampled at grant.
- ps_dm_wait  in  WAIT_W  DM wait states for the current access; sampled at grant.
- ps_gnt  out  4  one-hot grant, valid for the whole transaction.
- ps_done  out  1  one-cycle pulse in the final cycle of a transaction.
- ps_bc_drr_slct  out  2  registered drr select.
- ps_bc_di_slct  out  2  registered di select.
- ps_stall  out  1  high while any requester is waiting or a multi-cycle transaction is in progress.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; ps_gnt=0, ps_done=0, ps_stall=0.
  - ps_bc_drr_slct=2'b11, ps_bc_di_slct=2'b11; rr pointer=1.
  - Reset mid-transaction aborts it; no ps_done is issued.
- States: IDLE, XFER, WAIT.
- IDLE:
  - If ps_req!=0, choose a winner. Next edge: grant registered, selects registered, capture wait count; go to XFER.
  - Grant latency is 1 cycle after the request is seen.
- Priority:
  - bit0 (immediate) is fixed highest.
  - bits1..3 are round-robin starting from the rr pointer.
  - The pointer advances to winner+1 (wrapping 3→1) when a round-robin winner completes.
- XFER:
  - Non-DM grants, or DM with wait=0: ps_done=1 in this cycle. Next state IDLE, or back-to-back re-arbitration (see below).
  - DM with wait>0: go to WAIT with counter=wait.
- WAIT:
  - Counter decrements each cycle; ps_done asserted in the cycle the counter is 1; then exit as from XFER.
  - A DM access with wait=N occupies N+1 cycles.
- Back-to-back: in the ps_done cycle, arbitration runs on ps_req with the completing bit masked. The next grant starts on the following edge with no idle bubble.
- Select encoding, registered with ps_gnt:
  - Immediate: di=10, drr=11.
  - Stack pop: di=01, drr=01.
  - DM read: di=00, drr=11.
  - DM write, or stack push: di=01; drr decoded from ps_ureg_add (see source decode).
  - Ureg transfer: di=01; drr from the same source decode.
  - Idle: di=11, drr=11.
- Source decode (ps_ureg_add): 0→10; 6 or 7→01; 1 or 2→00; any other value→11.
- Selects return to 11/11 on the edge after ps_done if nothing is re-granted.
- ps_stall is combinational: (ps_req & ~ps_gnt)!=0, OR state==WAIT, OR (state==XFER and a DM wait is pending).
- Request dropped before grant: it is ignored. Request dropped while granted: no effect; the transaction runs to completion.
- ps_gnt is always one-hot or zero; never two bits set.
- Inputs sampled at grant are not re-read mid-transaction.

Test Plan:
- Reset then ps_req=4'b0001 → next edge ps_gnt=0001, di=10, drr=11, ps_done=1 in the same cycle; idle 11/11 one cycle later.
- ps_req=4'b1110 held continuously, no waits → grants 0010, 0100, 1000, 0010 on consecutive cycles; ps_done every cycle; no bubble.
- DM write, ps_ureg_add=6, ps_dm_wait=2 → ps_gnt=0100 for 3 cycles; di=01, drr=01; ps_done only in the 3rd cycle; ps_stall high during the first 2.
- During a DM wait, raise bit0 and bit3 → immediate granted first after DM done, then ureg; ureg with ps_ureg_add=0 gives drr=10.
- Ureg transfer with ps_ureg_add sweep 0..15 → drr = 10, 00, 00, 11, 11, 11, 01, 01, 11 ×8.
- Assert rst_n=0 mid-WAIT → outputs immediately 0 grant and 11/11 selects, no ps_done; after release, the held request is re-granted from the rr pointer=1 ordering.
